// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
// Receive end of a toggle-signalled event link. The transmitter flips t_in once
// per event; this block synchronises t_in, turns every level change into a
// one-cycle pulse, queues events as a pending count drained by a valid/ready
// handshake, and keeps a wrapping total plus a sticky overflow flag.
//
// Optional feature macro: TOGGLE_ACK_EN (adds ack_toggle, flipped on each pop).
//
// Parameters
//   SYNC_STAGES : synchroniser depth on t_in (>= 2)
//   PEND_W      : pending counter width, saturates at 2^PEND_W-1
//   CNT_W       : wrapping total counter width
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   t_in       : asynchronous toggle line, one event per level change
//   clr        : synchronous clear of pend_cnt, total_cnt, overflow
//   evt_ready  : consumer takes one event when evt_valid & evt_ready
//   evt_pulse  : one-cycle pulse per detected transition
//   evt_valid  : pend_cnt is nonzero
//   pend_cnt   : events detected and not yet consumed
//   total_cnt  : events detected since reset/clr, wraps
//   overflow   : sticky, event arrived while pend_cnt saturated
//   ack_toggle : (TOGGLE_ACK_EN only) flips on every pop
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PEND_W      = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    input  logic              clr,
    input  logic              evt_ready,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              overflow
`ifdef TOGGLE_ACK_EN
    ,
    output logic              ack_toggle
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_evt_pulse;
    logic                   r_evt_valid;
    logic [PEND_W-1:0]      r_pend;
    logic [CNT_W-1:0]       r_total;
    logic                   r_ovf;

    logic                   w_evt;
    logic                   w_pop;
    logic [PEND_W-1:0]      w_pend_nxt;
    logic [CNT_W-1:0]       w_total_nxt;
    logic                   w_ovf_nxt;

    // Synchroniser chain and previous-level register; never touched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], t_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_evt = r_sync[SYNC_STAGES-1] ^ r_prev;
    assign w_pop = r_evt_valid & evt_ready;

    // Next-state for the counters; clr dominates both event and pop.
    always_comb begin
        w_pend_nxt  = r_pend;
        w_total_nxt = r_total;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_pend_nxt  = '0;
            w_total_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            if (w_evt) begin
                w_total_nxt = r_total + CNT_W'(1);
            end
            if (w_evt && !w_pop) begin
                // Saturated queue: event is lost, only the flag records it.
                if (r_pend == PEND_MAX) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_pend_nxt = r_pend + PEND_W'(1);
                end
            end else if (!w_evt && w_pop) begin
                w_pend_nxt = r_pend - PEND_W'(1);
            end
        end
    end

    // Registered outputs; evt_valid is registered from the next pend value so
    // it tracks pend_cnt exactly without a combinational output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_pulse <= 1'b0;
            r_evt_valid <= 1'b0;
            r_pend      <= '0;
            r_total     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_evt_pulse <= w_evt;
            r_evt_valid <= (w_pend_nxt != '0);
            r_pend      <= w_pend_nxt;
            r_total     <= w_total_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign evt_pulse = r_evt_pulse;
    assign evt_valid = r_evt_valid;
    assign pend_cnt  = r_pend;
    assign total_cnt = r_total;
    assign overflow  = r_ovf;

`ifdef TOGGLE_ACK_EN
    logic r_ack;

    // Two-phase acknowledge back to the transmitter; independent of clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= r_ack ^ w_pop;
        end
    end

    assign ack_toggle = r_ack;
`endif

endmodule

// File: tb/tb_toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_event_decoder
// Directed-vector bench for toggle_event_decoder with default parameters
// (SYNC_STAGES=2, PEND_W=4, CNT_W=8). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_toggle_event_decoder;

    logic       clk;
    logic       rst;
    logic       t_in;
    logic       clr;
    logic       evt_ready;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic [7:0] total_cnt;
    logic       overflow;
`ifdef TOGGLE_ACK_EN
    logic       ack_toggle;
`endif

    int n_vec;
    int n_err;
    int pulse_seen;

    toggle_event_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .total_cnt (total_cnt),
        .overflow  (overflow)
`ifdef TOGGLE_ACK_EN
        ,
        .ack_toggle(ack_toggle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare observed against expected and report a miscompare.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (evt_pulse === 1'b1) pulse_seen++;
    endtask

    // One toggle followed by enough cycles for it to be fully processed.
    task automatic toggle_settle();
        t_in = ~t_in;
        repeat (4) tick();
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pulse_seen = 0;
        rst = 1'b0;
        t_in = 1'b0;
        clr = 1'b0;
        evt_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_pulse", 32'(evt_pulse), 32'd0);
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_pend", 32'(pend_cnt), 32'd0);
        check_eq("rst_total", 32'(total_cnt), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        pulse_seen = 0;
        repeat (10) tick();
        check_eq("idle_no_pulse", 32'(pulse_seen), 32'd0);
        check_eq("idle_pend", 32'(pend_cnt), 32'd0);

        // Single event, latency SYNC_STAGES+1 edges
        t_in = 1'b1;
        tick();
        check_eq("lat_e0_pulse", 32'(evt_pulse), 32'd0);
        tick();
        check_eq("lat_e1_pulse", 32'(evt_pulse), 32'd0);
        check_eq("lat_e1_valid", 32'(evt_valid), 32'd0);
        tick();
        check_eq("lat_e2_pulse", 32'(evt_pulse), 32'd1);
        check_eq("lat_e2_pend", 32'(pend_cnt), 32'd1);
        check_eq("lat_e2_valid", 32'(evt_valid), 32'd1);
        check_eq("lat_e2_total", 32'(total_cnt), 32'd1);
        tick();
        check_eq("lat_e3_pulse", 32'(evt_pulse), 32'd0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_eq("pop_pend", 32'(pend_cnt), 32'd0);
        check_eq("pop_valid", 32'(evt_valid), 32'd0);

        // Saturation and overflow
        clr_pulse();
        check_eq("clr0_total", 32'(total_cnt), 32'd0);
        pulse_seen = 0;
        repeat (16) toggle_settle();
        check_eq("sat_pulses", 32'(pulse_seen), 32'd16);
        check_eq("sat_pend", 32'(pend_cnt), 32'd15);
        check_eq("sat_total", 32'(total_cnt), 32'd16);
        check_eq("sat_ovf", 32'(overflow), 32'd1);
        check_eq("sat_valid", 32'(evt_valid), 32'd1);
        clr_pulse();
        check_eq("clr_pend", 32'(pend_cnt), 32'd0);
        check_eq("clr_total", 32'(total_cnt), 32'd0);
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        check_eq("clr_valid", 32'(evt_valid), 32'd0);
        pulse_seen = 0;
        repeat (5) tick();
        check_eq("clr_no_pulse", 32'(pulse_seen), 32'd0);

        // Event and pop on the same edge, then drain to empty
        repeat (3) toggle_settle();
        check_eq("pre_sim_pend", 32'(pend_cnt), 32'd3);
        t_in = ~t_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        check_eq("sim_pulse", 32'(evt_pulse), 32'd1);
        check_eq("sim_pend", 32'(pend_cnt), 32'd3);
        check_eq("sim_total", 32'(total_cnt), 32'd4);
        tick();
        check_eq("drain_pend2", 32'(pend_cnt), 32'd2);
        tick();
        check_eq("drain_valid1", 32'(evt_valid), 32'd1);
        tick();
        check_eq("drain_pend0", 32'(pend_cnt), 32'd0);
        check_eq("drain_valid0", 32'(evt_valid), 32'd0);
        tick();
        check_eq("no_underflow", 32'(pend_cnt), 32'd0);
        evt_ready = 1'b0;

        // clr coincident with an event: pulse fires, counters stay clear
        t_in = ~t_in;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clrevt_pulse", 32'(evt_pulse), 32'd1);
        check_eq("clrevt_pend", 32'(pend_cnt), 32'd0);
        check_eq("clrevt_total", 32'(total_cnt), 32'd0);
        tick();
        check_eq("clrevt_after", 32'(evt_pulse), 32'd0);

        // Total counter wrap with consumer always ready
        clr_pulse();
        evt_ready = 1'b1;
        pulse_seen = 0;
        repeat (256) toggle_settle();
        check_eq("wrap256_total", 32'(total_cnt), 32'd0);
        toggle_settle();
        check_eq("wrap_pulses", 32'(pulse_seen), 32'd257);
        check_eq("wrap_total", 32'(total_cnt), 32'd1);
        check_eq("wrap_pend", 32'(pend_cnt), 32'd0);
        check_eq("wrap_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b0;

        // Reset mid-operation with t_in high
        toggle_settle();
        clr_pulse();
        repeat (5) toggle_settle();
        check_eq("mid_tin", 32'(t_in), 32'd1);
        check_eq("mid_pend", 32'(pend_cnt), 32'd5);
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        check_eq("mid_pend_pop", 32'(pend_cnt), 32'd2);
`ifdef TOGGLE_ACK_EN
        check_eq("mid_ack", 32'(ack_toggle), 32'd1);
`endif
        rst = 1'b0;
        #1;
        check_eq("arst_pulse", 32'(evt_pulse), 32'd0);
        check_eq("arst_valid", 32'(evt_valid), 32'd0);
        check_eq("arst_pend", 32'(pend_cnt), 32'd0);
        check_eq("arst_total", 32'(total_cnt), 32'd0);
        check_eq("arst_ovf", 32'(overflow), 32'd0);
`ifdef TOGGLE_ACK_EN
        check_eq("arst_ack", 32'(ack_toggle), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("rel_e0_pulse", 32'(evt_pulse), 32'd0);
        tick();
        check_eq("rel_e1_pulse", 32'(evt_pulse), 32'd0);
        tick();
        check_eq("rel_e2_pulse", 32'(evt_pulse), 32'd1);
        check_eq("rel_e2_pend", 32'(pend_cnt), 32'd1);
        check_eq("rel_e2_total", 32'(total_cnt), 32'd1);
        tick();
        check_eq("rel_e3_pulse", 32'(evt_pulse), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
